// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port MIPS32 register file family.
package reg_file_mp_pkg;

  localparam int MIPS_DATA_W   = 32;
  localparam int MIPS_ADDR_W   = 5;
  localparam int MIPS_REG_ZERO = 0;
  localparam int MIPS_NUM_RD   = 3;

endpackage : reg_file_mp_pkg

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register override, optional write bypass,
// then stored value gated by the scoreboard busy bit.
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] data,
  output logic              ready
);

  // Port 1 is checked before port 0 so the forwarded value matches what gets stored.
  always_comb begin
    data  = stored;
    ready = ~busy;
    if (ZERO_REG != 0 && addr == ADDR_W'(MIPS_REG_ZERO)) begin
      data  = '0;
      ready = 1'b1;
    end else if (BYPASS != 0 && we1 && wa1 == addr) begin
      data  = wd1;
      ready = 1'b1;
    end else if (BYPASS != 0 && we0 && wa0 == addr) begin
      data  = wd0;
      ready = 1'b1;
    end
  end

endmodule : rf_read_port

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two synchronous writes
// (port 1 wins), optional write bypass and a per-register busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int NUM_RD   = MIPS_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       RegWrite0,
  input  logic [ADDR_W-1:0]          WriteRegister0,
  input  logic [DATA_W-1:0]          WriteData0,
  input  logic                       RegWrite1,
  input  logic [ADDR_W-1:0]          WriteRegister1,
  input  logic [DATA_W-1:0]          WriteData1,
  input  logic [NUM_RD*ADDR_W-1:0]   ReadRegister,
  output logic [NUM_RD*DATA_W-1:0]   ReadData,
  output logic [NUM_RD-1:0]          ReadReady,
  input  logic                       MarkBusy,
  input  logic [ADDR_W-1:0]          MarkRegister,
  output logic [(2**ADDR_W)-1:0]     BusyVec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] rf_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic              wr_ok0;
  logic              wr_ok1;
  logic              mark_ok;

  // Address 0 is a sink when hardwired: neither stored nor marked busy.
  assign wr_ok0  = RegWrite0 && !(ZERO_REG != 0 && WriteRegister0 == ADDR_W'(MIPS_REG_ZERO));
  assign wr_ok1  = RegWrite1 && !(ZERO_REG != 0 && WriteRegister1 == ADDR_W'(MIPS_REG_ZERO));
  assign mark_ok = MarkBusy  && !(ZERO_REG != 0 && MarkRegister   == ADDR_W'(MIPS_REG_ZERO));

  // Clears first, set last: a fresh producer issued this cycle keeps the register pending.
  always_comb begin
    busy_next = busy_reg;
    if (wr_ok0)  busy_next[WriteRegister0] = 1'b0;
    if (wr_ok1)  busy_next[WriteRegister1] = 1'b0;
    if (mark_ok) busy_next[MarkRegister]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf_reg[i] <= '0;
      busy_reg <= '0;
    end else begin
      if (wr_ok0) rf_reg[WriteRegister0] <= WriteData0;
      // Later assignment wins, giving port 1 priority on an address collision.
      if (wr_ok1) rf_reg[WriteRegister1] <= WriteData1;
      busy_reg <= busy_next;
    end
  end

  assign BusyVec = busy_reg;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      assign rd_addr = ReadRegister[gi*ADDR_W +: ADDR_W];

      rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
      ) u_port (
        .addr   (rd_addr),
        .stored (rf_reg[rd_addr]),
        .busy   (busy_reg[rd_addr]),
        .we0    (RegWrite0),
        .wa0    (WriteRegister0),
        .wd0    (WriteData0),
        .we1    (RegWrite1),
        .wa1    (WriteRegister1),
        .wd1    (WriteData1),
        .data   (ReadData[gi*DATA_W +: DATA_W]),
        .ready  (ReadReady[gi])
      );
    end
  endgenerate

endmodule : reg_file_mp
